cgra_conf_loader: RTL and testbench

Upstream configuration stage of the CGRA array. Accepts the 352-bit array configuration (16 PEs × 22 bits) as a stream of 32-bit words over a valid/ready handshake and assembles it in a shadow register. On a swap request it publishes the shadow image to the active `conf` bus that feeds the branch/merge decoder and PE datapath. This lets the next configuration load while the current one runs.

---
 rtl/cgra_conf_loader.sv | 146 ++++++++++++++
 tb/tb_cgra_conf_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cgra_conf_loader.sv
// Assembles a 352-bit CGRA configuration image from a 32-bit word stream into a shadow register and publishes it to conf on swap.
// Optional per-word even-parity checking with a sticky error flag is enabled by defining CONF_LOADER_PARITY_EN.
module cgra_conf_loader #(
  parameter int CONF_WIDTH = 352,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  clear,
  input  logic                  swap,
  output logic [CONF_WIDTH-1:0] conf,
  output logic                  conf_valid,
  output logic                  shadow_full
`ifdef CONF_LOADER_PARITY_EN
  ,
  output logic                  err,
  input  logic                  in_parity
`endif
);

  localparam int SHADOW_W = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SHADOW_W-1:0]     shadow_q, shadow_d;
  logic [CONF_WIDTH-1:0]   conf_q, conf_d;
  logic                    conf_valid_q, conf_valid_d;
  logic                    full_q, full_d;
  logic                    xfer_s;
  logic                    word_ok_s;

`ifdef CONF_LOADER_PARITY_EN
  logic                    err_q, err_d;

  // Even parity over data plus parity bit must reduce to zero.
  function automatic logic parity_ok(input logic [WORD_WIDTH-1:0] data, input logic par);
    return ~(^{data, par});
  endfunction

  assign word_ok_s = parity_ok(in_data, in_parity);
  assign err       = err_q;
`else
  assign word_ok_s = 1'b1;
`endif

  // in_ready depends on the state register only, never on in_valid.
  assign in_ready    = (state_q != S_FULL);
  assign xfer_s      = in_valid && in_ready;
  assign conf        = conf_q;
  assign conf_valid  = conf_valid_q;
  assign shadow_full = full_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    conf_d       = conf_q;
    conf_valid_d = conf_valid_q;
`ifdef CONF_LOADER_PARITY_EN
    err_d        = err_q;
`endif
    if (clear) begin
      // clear wins over swap and drops any concurrent word
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
`ifdef CONF_LOADER_PARITY_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (xfer_s && !word_ok_s) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
`ifdef CONF_LOADER_PARITY_EN
            err_d   = 1'b1;
`endif
          end else if (xfer_s) begin
            shadow_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = in_data;
            if (cnt_q == CNT_LAST) begin
              state_d = S_FULL;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              state_d = S_LOAD;
              cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = state_q;
          end
        end
        S_FULL: begin
          if (swap) begin
            conf_d       = shadow_q[CONF_WIDTH-1:0];
            conf_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_FULL;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
    full_d = (state_d == S_FULL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      shadow_q     <= {SHADOW_W{1'b0}};
      conf_q       <= {CONF_WIDTH{1'b0}};
      conf_valid_q <= 1'b0;
      full_q       <= 1'b0;
`ifdef CONF_LOADER_PARITY_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      conf_q       <= conf_d;
      conf_valid_q <= conf_valid_d;
      full_q       <= full_d;
`ifdef CONF_LOADER_PARITY_EN
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cgra_conf_loader.sv
// Randomized self-checking bench for cgra_conf_loader against a queue-based reference model.
// Parity scenarios are exercised when CONF_LOADER_PARITY_EN is defined.
module tb_cgra_conf_loader;

  localparam int CW = 352;
  localparam int WW = 32;
  localparam int NW = 11;
`ifdef CONF_LOADER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [WW-1:0] in_data;
  logic          in_ready;
  logic          clear;
  logic          swap;
  logic [CW-1:0] conf;
  logic          conf_valid;
  logic          shadow_full;
`ifdef CONF_LOADER_PARITY_EN
  logic          err;
  logic          in_parity;
`endif

  always #5 clk = ~clk;

  cgra_conf_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .clear       (clear),
    .swap        (swap),
    .conf        (conf),
    .conf_valid  (conf_valid),
    .shadow_full (shadow_full)
`ifdef CONF_LOADER_PARITY_EN
    ,
    .err         (err),
    .in_parity   (in_parity)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words accepted so far, whether an image waits for swap, published image.
  logic [WW-1:0] m_q[$];
  bit            m_full;
  logic [CW-1:0] m_conf;
  bit            m_cv;
  bit            m_err;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] build_img();
    logic [NW*WW-1:0] img;
    img = '0;
    foreach (m_q[k]) img[k*WW +: WW] = m_q[k];
    return img[CW-1:0];
  endfunction

  task automatic check_outputs();
    check_eq("in_ready", CW'(in_ready), CW'(!m_full));
    check_eq("shadow_full", CW'(shadow_full), CW'(m_full));
    check_eq("conf_valid", CW'(conf_valid), CW'(m_cv));
    check_eq("conf", conf, m_conf);
`ifdef CONF_LOADER_PARITY_EN
    check_eq("err", CW'(err), CW'(m_err));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit v, input logic [WW-1:0] d, input bit sw, input bit cl, input bit par_bad);
    bit bad;
    in_valid = v;
    in_data  = d;
    swap     = sw;
    clear    = cl;
`ifdef CONF_LOADER_PARITY_EN
    in_parity = (^d) ^ par_bad;
`endif
    bad = par_bad && PAR_EN;
    if (cl) begin
      m_q.delete();
      m_full = 1'b0;
      m_err  = 1'b0;
    end else if (m_full) begin
      if (sw) begin
        m_conf = build_img();
        m_cv   = 1'b1;
        m_full = 1'b0;
        m_q.delete();
      end
    end else if (v) begin
      if (bad) begin
        m_q.delete();
        m_err = 1'b1;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == NW) m_full = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    swap     = 1'b0;
    clear    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete();
    m_full = 1'b0;
    m_conf = '0;
    m_cv   = 1'b0;
    m_err  = 1'b0;
    check_outputs();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    swap     = 1'b0;
    clear    = 1'b0;
`ifdef CONF_LOADER_PARITY_EN
    in_parity = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Reset then load words 0..10 and swap.
    for (int k = 0; k < NW; k++) cycle(1'b1, WW'(k), 1'b0, 1'b0, 1'b0);
    check_eq("full_after_load", CW'(shadow_full), CW'(1'b1));
    check_eq("ready_in_full", CW'(in_ready), CW'(1'b0));
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("conf_w0", CW'(conf[31:0]), CW'(32'h0));
    check_eq("conf_w1", CW'(conf[63:32]), CW'(32'h1));
    check_eq("conf_w10", CW'(conf[351:320]), CW'(32'hA));
    check_eq("conf_valid_set", CW'(conf_valid), CW'(1'b1));

    // Backpressure and gaps: valid every other cycle, then a word held during FULL.
    for (int i = 0; i < 2 * NW; i++) cycle(i[0] == 1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hCAFE_0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0);
    check_eq("held_word_taken", CW'(m_q.size()), CW'(1));

    // Ignored swap during LOAD at cnt = 5.
    cycle(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 5; k < NW; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Clear at cnt = 7 with a concurrent transfer, then a full clean image.
    for (int k = 0; k < 7; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NW; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // clear and swap together in FULL leave conf untouched.
    for (int k = 0; k < NW; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Reset mid-load at cnt = 4 after a prior swap.
    for (int k = 0; k < 4; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_eq("rst_conf_zero", conf, '0);

    // Parity error on word 3, reload, then clear.
    if (PAR_EN) begin
      for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < NW; k++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
